// File: rtl/result_demux4.sv
// Steers one input word into one of four registered output slots by in_sel.
// Define RESULT_DEMUX_CNT_EN to add the per-slot drain counter port drain_cnt.
module result_demux4 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic [3:0]       out_valid,
`ifdef RESULT_DEMUX_CNT_EN
   output logic [31:0]      drain_cnt,
`endif
   input  logic [3:0]       out_ready
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } slot_st_t;

   slot_st_t         r_st   [4];
   slot_st_t         w_st_nx[4];
   logic [WIDTH-1:0] r_data [4];
   logic [3:0]       w_load;
   logic [3:0]       w_drain;
   logic             w_accept;

   always_comb begin
      in_ready = !out_valid[in_sel] | out_ready[in_sel];
      w_accept = in_valid & in_ready;
      for (int k = 0; k < 4; k++) begin
         out_valid[k] = (r_st[k] == S_FULL);
         w_load[k]    = w_accept && (in_sel == 2'(k));
         w_drain[k]   = out_valid[k] & out_ready[k];
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_st_nx[k] = r_st[k];
         unique case (r_st[k])
            S_EMPTY: if (w_load[k]) w_st_nx[k] = S_FULL;
            S_FULL:  if (w_drain[k] && !w_load[k]) w_st_nx[k] = S_EMPTY;
            default: w_st_nx[k] = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            r_st[k]   <= S_EMPTY;
            r_data[k] <= '0;
         end else begin
            r_st[k] <= w_st_nx[k];
            if (w_load[k]) r_data[k] <= in_data;
         end
      end
   end

   assign out_data0 = r_data[0];
   assign out_data1 = r_data[1];
   assign out_data2 = r_data[2];
   assign out_data3 = r_data[3];

`ifdef RESULT_DEMUX_CNT_EN
   logic [7:0] r_cnt[4];

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rst) r_cnt[k] <= '0;
         else if (w_drain[k]) r_cnt[k] <= r_cnt[k] + 8'd1;
      end
   end

   assign drain_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_result_demux4.sv
// Scoreboard bench for result_demux4: per-slot queues model held words.
// Honours RESULT_DEMUX_CNT_EN the same way as the design.
module tb_result_demux4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data0, out_data1, out_data2, out_data3;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
`ifdef RESULT_DEMUX_CNT_EN
   logic [31:0] drain_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   result_demux4 #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .out_valid (out_valid),
`ifdef RESULT_DEMUX_CNT_EN
      .drain_cnt (drain_cnt),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: each slot is a queue of words awaiting delivery.
   logic [31:0] q[4][$];
   logic [31:0] last[4];
   int          cnt[4];
   bit          seen_rst = 0;

   function automatic logic [31:0] dout(input int k);
      case (k)
         0: return out_data0;
         1: return out_data1;
         2: return out_data2;
         default: return out_data3;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last[k] = '0;
            cnt[k]  = 0;
         end
         seen_rst = 1;
      end else if (seen_rst) begin
         logic [3:0] ev;
         logic [31:0] ec;
         logic        er;
         for (int k = 0; k < 4; k++) ev[k] = (q[k].size() != 0);
         chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
         for (int k = 0; k < 4; k++)
            chk($sformatf("out_data%0d", k), dout(k), last[k]);
         er = (q[in_sel].size() == 0) || out_ready[in_sel];
         chk("in_ready", {31'd0, in_ready}, {31'd0, er});
`ifdef RESULT_DEMUX_CNT_EN
         ec = {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
         chk("drain_cnt", drain_cnt, ec);
`else
         ec = '0;
`endif
         for (int k = 0; k < 4; k++) begin
            if (out_ready[k] && q[k].size() != 0) begin
               chk($sformatf("drain%0d", k), dout(k), q[k].pop_front());
               cnt[k] = (cnt[k] + 1) % 256;
            end
         end
         if (in_valid && er) begin
            q[in_sel].push_back(in_data);
            last[in_sel] = in_data;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      out_ready = 4'b0000;
   endtask

   initial begin
      rst = 1'b1;
      in_data = '0;
      in_sel = '0;
      idle();
      step();
      step();
      rst = 1'b0;

      // single load to slot 2
      in_data = 32'hDEADBEEF; in_sel = 2'd2; in_valid = 1'b1;
      step();
      idle();
      @(negedge clk);
      chk("r028_valid", {28'd0, out_valid}, 32'h4);
      chk("r028_data2", out_data2, 32'hDEADBEEF);
      chk("r028_data0", out_data0, 32'h0);

      // blocked sender holds a word for slot 1
      step();
      in_data = 32'h11; in_sel = 2'd1; in_valid = 1'b1;
      step();
      in_data = 32'h22;
      @(negedge clk);
      chk("r029_ready", {31'd0, in_ready}, 32'h0);
      step(); step(); step();
      chk("r029_data1", out_data1, 32'h11);
      idle();
      out_ready = 4'hF;
      step();

      // drain and reload slot 3 in one cycle
      idle();
      in_data = 32'h1; in_sel = 2'd3; in_valid = 1'b1;
      step();
      in_data = 32'h2; out_ready = 4'b1000;
      @(negedge clk);
      chk("r030_ready", {31'd0, in_ready}, 32'h1);
      step();
      idle();
      @(negedge clk);
      chk("r030_valid3", {31'd0, out_valid[3]}, 32'h1);
      chk("r030_data3", out_data3, 32'h2);
      step();
      out_ready = 4'hF;
      step();

      // fill all four slots, then drain together
      idle();
      for (int k = 0; k < 4; k++) begin
         in_data = 32'hA0 + k; in_sel = 2'(k); in_valid = 1'b1;
         step();
      end
      idle();
      @(negedge clk);
      chk("r031_full", {28'd0, out_valid}, 32'hF);
      chk("r031_d1", out_data1, 32'hA1);
      chk("r031_d3", out_data3, 32'hA3);
      step();
      out_ready = 4'hF;
      step();
      idle();
      @(negedge clk);
      chk("r031_empty", {28'd0, out_valid}, 32'h0);

      // reset wins over a same-cycle accept
      step();
      in_data = 32'h55; in_sel = 2'd0; in_valid = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      @(negedge clk);
      chk("r032_valid", {28'd0, out_valid}, 32'h0);
      chk("r032_data0", out_data0, 32'h0);
      chk("r032_ready", {31'd0, in_ready}, 32'h1);

`ifdef RESULT_DEMUX_CNT_EN
      step();
      in_data = 32'h7; in_sel = 2'd0; in_valid = 1'b1; out_ready = 4'b0001;
      for (int i = 0; i < 257; i++) step();
      in_valid = 1'b0;
      step();
      idle();
      @(negedge clk);
      chk("r033_cnt", drain_cnt, 32'h1);
`endif

      // randomized traffic with occasional reset
      step();
      for (int i = 0; i < 3000; i++) begin
         in_data   = $urandom;
         in_sel    = 2'($urandom_range(0, 3));
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 4'($urandom);
         rst       = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      idle();
      step();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
